fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_fetch_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: IDLE/RUN/HALT FSM with branch, jump and call/return PC select.
// Return-address stack is built only when FETCH_CTRL_RAS_EN is defined.
module fetch_ctrl #(
    parameter int PC_W      = 8,
    parameter int OFF_W     = 6,
    parameter int RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            Reset_N,
    input  logic            Start,
    input  logic [PC_W-1:0] Start_Addr,
    input  logic [PC_W-1:0] End_Addr,
    input  logic            Stall,
    input  logic            Branch,
    input  logic            Zero,
    input  logic [OFF_W-1:0] Offset,
    input  logic            Jump,
    input  logic            Call,
    input  logic            Ret,
    input  logic [PC_W-1:0] Target,
    output logic [PC_W-1:0] PC,
    output logic            Running,
    output logic            Done,
    output logic            Ras_Err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc, off_ext, br_tgt;
    logic            err_q, err_d;

    assign pc_inc  = pc_q + PC_W'(1);
    assign off_ext = PC_W'($signed(Offset));
    assign br_tgt  = pc_q + off_ext;

`ifdef FETCH_CTRL_RAS_EN
    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [PC_W-1:0] ras_q [RAS_DEPTH];
    logic [PC_W-1:0] ras_d [RAS_DEPTH];
    logic [SP_W-1:0] sp_q, sp_d, sp_m1;
    logic            ras_full, ras_empty;

    assign sp_m1     = sp_q - SP_W'(1);
    assign ras_full  = (sp_q == SP_W'(RAS_DEPTH));
    assign ras_empty = (sp_q == '0);
`else
    logic unused_cfg;
    assign unused_cfg = Ret ^ (RAS_DEPTH > 1);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
`ifdef FETCH_CTRL_RAS_EN
        sp_d    = sp_q;
        ras_d   = ras_q;
`endif
        if (Start) begin
            pc_d    = Start_Addr;
            state_d = RUN;
            err_d   = 1'b0;
`ifdef FETCH_CTRL_RAS_EN
            sp_d    = '0;
`endif
        end else if (state_q == RUN && !Stall) begin
            if (pc_q == End_Addr) begin
                state_d = HALT;
`ifdef FETCH_CTRL_RAS_EN
            end else if (Ret) begin
                if (ras_empty) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    pc_d = ras_q[sp_m1[IDX_W-1:0]];
                    sp_d = sp_m1;
                end
            end else if (Call) begin
                pc_d = Target;
                if (ras_full) begin
                    err_d = 1'b1;
                end else begin
                    ras_d[sp_q[IDX_W-1:0]] = pc_inc;
                    sp_d = sp_q + SP_W'(1);
                end
            end else if (Jump) begin
                pc_d = Target;
`else
            end else if (Call || Jump) begin
                pc_d = Target;
`endif
            end else if (Branch && Zero) begin
                pc_d = br_tgt;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= IDLE;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

`ifdef FETCH_CTRL_RAS_EN
    always_ff @(posedge CLK or negedge Reset_N) begin
        if (!Reset_N) begin
            sp_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            sp_q  <= sp_d;
            ras_q <= ras_d;
        end
    end
`endif

    assign PC      = pc_q;
    assign Running = (state_q == RUN);
    assign Done    = (state_q == HALT);
    assign Ras_Err = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl (PC_W=8, OFF_W=6, RAS_DEPTH=4).
module tb_fetch_ctrl;

    logic       CLK;
    logic       Reset_N;
    logic       Start, Stall, Branch, Zero, Jump, Call, Ret;
    logic [7:0] Start_Addr, End_Addr, Target;
    logic [5:0] Offset;
    logic [7:0] PC;
    logic       Running, Done, Ras_Err;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [6:0] NO = 7'b0000000;
    localparam logic [6:0] ST = 7'b1000000;
    localparam logic [6:0] SL = 7'b0100000;
    localparam logic [6:0] BR = 7'b0010000;
    localparam logic [6:0] ZE = 7'b0001000;
    localparam logic [6:0] JP = 7'b0000100;
    localparam logic [6:0] CA = 7'b0000010;
    localparam logic [6:0] RT = 7'b0000001;

    localparam logic [2:0] F_I  = 3'b000;
    localparam logic [2:0] F_R  = 3'b100;
    localparam logic [2:0] F_D  = 3'b010;
    localparam logic [2:0] F_RE = 3'b101;

    typedef struct {
        string      tag;
        logic [7:0] pc;
        logic [2:0] fl;
    } exp_t;

    exp_t sb[$];

    fetch_ctrl #(.PC_W(8), .OFF_W(6), .RAS_DEPTH(4)) dut (
        .CLK(CLK), .Reset_N(Reset_N),
        .Start(Start), .Start_Addr(Start_Addr), .End_Addr(End_Addr),
        .Stall(Stall), .Branch(Branch), .Zero(Zero), .Offset(Offset),
        .Jump(Jump), .Call(Call), .Ret(Ret), .Target(Target),
        .PC(PC), .Running(Running), .Done(Done), .Ras_Err(Ras_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check();
        exp_t e;
        logic [10:0] got, want;
        e = sb.pop_front();
        got  = {PC, Running, Done, Ras_Err};
        want = {e.pc, e.fl};
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got pc=%h run/done/err=%b, expected pc=%h run/done/err=%b",
                   e.tag, got[10:3], got[2:0], want[10:3], want[2:0]);
        end
    endtask

    task automatic now(input string tag, input logic [7:0] epc,
                       input logic [2:0] efl);
        sb.push_back('{tag, epc, efl});
        check();
    endtask

    task automatic step(input string tag, input logic [6:0] c,
                        input logic [5:0] off, input logic [7:0] tgt,
                        input logic [7:0] epc, input logic [2:0] efl);
        {Start, Stall, Branch, Zero, Jump, Call, Ret} = c;
        Offset = off;
        Target = tgt;
        sb.push_back('{tag, epc, efl});
        @(posedge CLK);
        #1;
        check();
    endtask

    initial begin
        Reset_N = 1'b0;
        {Start, Stall, Branch, Zero, Jump, Call, Ret} = NO;
        Start_Addr = 8'h00;
        End_Addr   = 8'h00;
        Target     = 8'h00;
        Offset     = 6'd0;
        #3;
        now("rst", 8'h00, F_I);
        @(posedge CLK);
        #1;
        now("rst_edge", 8'h00, F_I);
        #5;
        Reset_N = 1'b1;

        step("idle", NO, 6'd0, 8'h00, 8'h00, F_I);

        Start_Addr = 8'h10;
        End_Addr   = 8'h13;
        step("start", ST | SL, 6'd0, 8'h00, 8'h10, F_R);
        step("seq11", NO, 6'd0, 8'h00, 8'h11, F_R);
        step("seq12", NO, 6'd0, 8'h00, 8'h12, F_R);
        step("seq13", NO, 6'd0, 8'h00, 8'h13, F_R);
        step("end_stall", SL, 6'd0, 8'h00, 8'h13, F_R);
        step("end", JP, 6'd0, 8'h55, 8'h13, F_D);
        step("halt", JP | CA | RT, 6'd0, 8'h55, 8'h13, F_D);

        End_Addr   = 8'hFF;
        Start_Addr = 8'h20;
        step("st20", ST, 6'd0, 8'h00, 8'h20, F_R);
        step("br_back", BR | ZE, 6'b111100, 8'h00, 8'h1C, F_R);
        step("st20b", ST, 6'd0, 8'h00, 8'h20, F_R);
        step("br_nz", BR, 6'b111100, 8'h00, 8'h21, F_R);
        Start_Addr = 8'hFE;
        step("stFE", ST, 6'd0, 8'h00, 8'hFE, F_R);
        step("br_wrap", BR | ZE, 6'd3, 8'h00, 8'h01, F_R);
        step("br_maxpos", BR | ZE, 6'b011111, 8'h00, 8'h20, F_R);
        step("jmp_pri", JP | BR | ZE, 6'd3, 8'h77, 8'h77, F_R);
        step("stall", SL | JP | BR | ZE, 6'd3, 8'h00, 8'h77, F_R);
        step("inc78", NO, 6'd0, 8'h00, 8'h78, F_R);

        End_Addr   = 8'h00;
        Start_Addr = 8'hFF;
        step("stFF", ST, 6'd0, 8'h00, 8'hFF, F_R);
        step("inc_wrap", NO, 6'd0, 8'h00, 8'h00, F_R);
        step("end_wrap", NO, 6'd0, 8'h00, 8'h00, F_D);

        End_Addr = 8'hFF;
`ifdef FETCH_CTRL_RAS_EN
        Start_Addr = 8'h30;
        step("st30", ST, 6'd0, 8'h00, 8'h30, F_R);
        step("call80", CA, 6'd0, 8'h80, 8'h80, F_R);
        step("inc81", NO, 6'd0, 8'h00, 8'h81, F_R);
        step("stall_a", SL | RT, 6'd0, 8'h00, 8'h81, F_R);
        step("stall_b", SL | RT, 6'd0, 8'h00, 8'h81, F_R);
        step("inc82", NO, 6'd0, 8'h00, 8'h82, F_R);
        step("inc83", NO, 6'd0, 8'h00, 8'h83, F_R);
        step("inc84", NO, 6'd0, 8'h00, 8'h84, F_R);
        step("inc85", NO, 6'd0, 8'h00, 8'h85, F_R);
        step("ret31", RT, 6'd0, 8'h00, 8'h31, F_R);

        Start_Addr = 8'h40;
        step("st40n", ST, 6'd0, 8'h00, 8'h40, F_R);
        step("call1", CA, 6'd0, 8'h50, 8'h50, F_R);
        step("call2", CA, 6'd0, 8'h60, 8'h60, F_R);
        step("call3", CA, 6'd0, 8'h70, 8'h70, F_R);
        step("call4", CA, 6'd0, 8'h80, 8'h80, F_R);
        step("call5_ovf", CA, 6'd0, 8'h90, 8'h90, F_RE);
        step("ret1", RT, 6'd0, 8'h00, 8'h71, F_RE);
        step("ret2", RT, 6'd0, 8'h00, 8'h61, F_RE);
        step("ret3", RT, 6'd0, 8'h00, 8'h51, F_RE);
        step("ret4", RT, 6'd0, 8'h00, 8'h41, F_RE);
        step("ret5_unf", RT, 6'd0, 8'h00, 8'h42, F_RE);
        step("ret_call_pri", RT | CA, 6'd0, 8'h99, 8'h43, F_RE);
        step("ret_empty2", RT, 6'd0, 8'h00, 8'h44, F_RE);

        Start_Addr = 8'h10;
        step("st_clr", ST, 6'd0, 8'h00, 8'h10, F_R);
        step("call60", CA, 6'd0, 8'h60, 8'h60, F_R);
        Start_Addr = 8'h20;
        step("st_ret", ST | RT, 6'd0, 8'h00, 8'h20, F_R);
        step("ret_flushed", RT, 6'd0, 8'h00, 8'h21, F_RE);
`else
        Start_Addr = 8'h30;
        step("st30", ST, 6'd0, 8'h00, 8'h30, F_R);
        step("call_jmp", CA, 6'd0, 8'h80, 8'h80, F_R);
        step("stall_a", SL | RT | CA, 6'd0, 8'h11, 8'h80, F_R);
        step("stall_b", SL | RT, 6'd0, 8'h11, 8'h80, F_R);
        step("ret_none", RT, 6'd0, 8'h00, 8'h81, F_R);
        step("ret_none2", RT | BR | ZE, 6'd2, 8'h00, 8'h83, F_R);
        step("call_pri", CA | JP | BR | ZE, 6'd2, 8'h44, 8'h44, F_R);
        Start_Addr = 8'h20;
        step("st_ret", ST | RT, 6'd0, 8'h00, 8'h20, F_R);
`endif

        Start_Addr = 8'h40;
        step("st40", ST, 6'd0, 8'h00, 8'h40, F_R);
        step("inc41", NO, 6'd0, 8'h00, 8'h41, F_R);
        #2;
        Reset_N = 1'b0;
        #1;
        now("rst_async", 8'h00, F_I);
        {Start, Stall, Branch, Zero, Jump, Call, Ret} = JP;
        Target = 8'h66;
        @(posedge CLK);
        #1;
        now("rst_hold", 8'h00, F_I);
        #3;
        Reset_N = 1'b1;
        step("post_rst", JP, 6'd0, 8'h66, 8'h00, F_I);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
